// File: rtl/imm_encoder_pkg.sv
// Shared constants and enum types for the immediate encoder and its classifier.
package imm_pkg;

    localparam int W_SHORT = 10;
    localparam int W_MID   = 12;
    localparam int W_LONG  = 20;
    localparam int FIELD_W = 24;

    localparam logic [1:0] IMM_SRC_SHORT = 2'd0;
    localparam logic [1:0] IMM_SRC_MID   = 2'd1;
    localparam logic [1:0] IMM_SRC_LONG  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT_ONE = 2'd1,
        ST_EMIT_HI  = 2'd2,
        ST_EMIT_LO  = 2'd3
    } imm_state_e;

    typedef enum logic [1:0] {
        CLS_SHORT = 2'd0,
        CLS_MID   = 2'd1,
        CLS_LONG  = 2'd2,
        CLS_SPLIT = 2'd3
    } imm_class_e;

endpackage

// File: rtl/imm_encoder_classify.sv
// Picks the narrowest unsigned immediate format that holds a 32-bit value.
module imm_classify
    import imm_pkg::*;
(
    input  logic [31:0] i_value,
    output imm_class_e  o_class
);

    always_comb begin
        if (i_value[31:W_SHORT] == '0) begin
            o_class = CLS_SHORT;
        end else if (i_value[31:W_MID] == '0) begin
            o_class = CLS_MID;
        end else if (i_value[31:W_LONG] == '0) begin
            o_class = CLS_LONG;
        end else begin
            o_class = CLS_SPLIT;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Encodes a 32-bit constant into one immediate beat or an upper/lower pair.
// Build option: IMM_ENCODER_SKIP_ZERO_LO_EN drops the lower beat when value[11:0] is zero.
module imm_encoder
    import imm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_imm_src,
    output logic [FIELD_W-1:0] out_field,
    output logic               out_upper,
    output logic               out_last,
    output logic               busy
);

`ifdef IMM_ENCODER_SKIP_ZERO_LO_EN
    localparam bit SKIP_ZERO_LO = 1'b1;
`else
    localparam bit SKIP_ZERO_LO = 1'b0;
`endif

    imm_state_e         r_state;
    imm_class_e         r_class;
    logic [31:0]        r_value;
    logic               r_out_valid;
    logic [1:0]         r_out_imm_src;
    logic [FIELD_W-1:0] r_out_field;
    logic               r_out_upper;
    logic               r_out_last;
    logic               r_busy;

    imm_class_e         w_in_class;
    imm_state_e         w_nstate;
    imm_class_e         w_nclass;
    logic [31:0]        w_nvalue;
    logic               w_accept;
    logic               w_fire;
    logic               w_hi_only_cur;
    logic               w_hi_only_nxt;
    logic               w_nvalid;
    logic [1:0]         w_nsrc;
    logic [FIELD_W-1:0] w_nfield;
    logic               w_nupper;
    logic               w_nlast;

    imm_classify u_classify (
        .i_value (in_value),
        .o_class (w_in_class)
    );

    assign w_fire   = r_out_valid && out_ready;
    assign in_ready = (r_state == ST_IDLE) || (w_fire && r_out_last);
    assign w_accept = in_valid && in_ready;

    assign w_hi_only_cur = SKIP_ZERO_LO && (r_value[11:0] == 12'd0);
    assign w_hi_only_nxt = SKIP_ZERO_LO && (w_nvalue[11:0] == 12'd0);

    // Next state: a final-beat transfer either reloads from the input or idles.
    always_comb begin
        w_nstate = r_state;
        w_nclass = r_class;
        w_nvalue = r_value;
        case (r_state)
            ST_IDLE: ;
            ST_EMIT_HI: begin
                if (w_fire && !w_hi_only_cur) begin
                    w_nstate = ST_EMIT_LO;
                end else if (w_fire) begin
                    w_nstate = ST_IDLE;
                end
            end
            default: begin
                if (w_fire) begin
                    w_nstate = ST_IDLE;
                end
            end
        endcase
        if (w_accept) begin
            w_nvalue = in_value;
            w_nclass = w_in_class;
            w_nstate = (w_in_class == CLS_SPLIT) ? ST_EMIT_HI : ST_EMIT_ONE;
        end
    end

    // Output values for the upcoming state, so every out_* comes straight from a flop.
    always_comb begin
        w_nvalid = 1'b0;
        w_nsrc   = 2'd0;
        w_nfield = '0;
        w_nupper = 1'b0;
        w_nlast  = 1'b0;
        case (w_nstate)
            ST_EMIT_ONE: begin
                w_nvalid = 1'b1;
                w_nlast  = 1'b1;
                case (w_nclass)
                    CLS_SHORT: begin
                        w_nsrc   = IMM_SRC_SHORT;
                        w_nfield = FIELD_W'(w_nvalue[W_SHORT-1:0]);
                    end
                    CLS_MID: begin
                        w_nsrc   = IMM_SRC_MID;
                        w_nfield = FIELD_W'(w_nvalue[W_MID-1:0]);
                    end
                    default: begin
                        w_nsrc   = IMM_SRC_LONG;
                        w_nfield = FIELD_W'(w_nvalue[W_LONG-1:0]);
                    end
                endcase
            end
            ST_EMIT_HI: begin
                w_nvalid = 1'b1;
                w_nsrc   = IMM_SRC_LONG;
                w_nfield = FIELD_W'(w_nvalue[31:12]);
                w_nupper = 1'b1;
                w_nlast  = w_hi_only_nxt;
            end
            ST_EMIT_LO: begin
                w_nvalid = 1'b1;
                w_nsrc   = IMM_SRC_MID;
                w_nfield = FIELD_W'(w_nvalue[11:0]);
                w_nlast  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_class       <= CLS_SHORT;
            r_value       <= '0;
            r_out_valid   <= 1'b0;
            r_out_imm_src <= 2'd0;
            r_out_field   <= '0;
            r_out_upper   <= 1'b0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_class       <= w_nclass;
            r_value       <= w_nvalue;
            r_out_valid   <= w_nvalid;
            r_out_imm_src <= w_nsrc;
            r_out_field   <= w_nfield;
            r_out_upper   <= w_nupper;
            r_out_last    <= w_nlast;
            r_busy        <= (w_nstate != ST_IDLE);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm_src = r_out_imm_src;
    assign out_field   = r_out_field;
    assign out_upper   = r_out_upper;
    assign out_last    = r_out_last;
    assign busy        = r_busy;

endmodule
